aurora_stripe_tx: RTL and testbench

AURORA_STRIPE_TX -- requirements
Module: aurora_stripe_tx

---
 rtl/aurora_stripe_tx.sv | 172 +++++++++++++++++
 tb/tb_aurora_stripe_tx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_stripe_tx.sv
// Purpose: stripes whole router packets round-robin over NCH Aurora AXI-S channels through per-channel FWFT FIFOs.
// Latency: one cycle from an accepted input word to its appearance on TX_TDATA of the selected channel.
// Backpressure: D_BP is high while idle/selecting and in PKT when the selected FIFO is full; drops never stall.
module aurora_stripe_tx #(
    parameter int NCH   = 4,
    parameter int DW    = 64,
    parameter int DEPTH = 16
) (
    input  logic              CLK,
    input  logic              SYS_RST,
    input  logic [DW-1:0]     D,
    input  logic              D_VALID,
    input  logic              D_LAST,
    output logic              D_BP,
    input  logic [NCH-1:0]    CH_UP,
    output logic [NCH*DW-1:0] TX_TDATA,
    output logic [NCH-1:0]    TX_TVALID,
    output logic [NCH-1:0]    TX_TLAST,
    input  logic [NCH-1:0]    TX_TREADY,
    output logic              BUSY,
    output logic [15:0]       DROP_CNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] LAST_RST = CW'(NCH - 1);

    typedef enum logic [1:0] {S_IDLE, S_PKT, S_DROP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] sel_q, sel_d;
    logic [CW-1:0] last_q, last_d;
    logic [15:0]   drop_q, drop_d;

    logic          found;
    logic [CW-1:0] pick;
    logic [CW-1:0] idx;
    logic [NCH-1:0] full_vec;
    logic          sel_up;
    logic          sel_full;
    logic          accept;
    logic          push;

    assign sel_up   = CH_UP[sel_q];
    assign sel_full = full_vec[sel_q];
    assign accept   = D_VALID && !D_BP;
    assign DROP_CNT = drop_q;

    // Round-robin search for the first up channel after the last one served.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 1; i <= NCH; i++) begin
            idx = CW'((int'(last_q) + i) % NCH);
            if (!found && CH_UP[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // State register with control registers for selection, rotation and drop count.
    always_ff @(posedge CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            last_q  <= LAST_RST;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state logic: select, forward a packet, or swallow the rest of a dead one.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        drop_d  = drop_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    sel_d   = pick;
                    state_d = S_PKT;
                end
            end
            S_PKT: begin
                if (!sel_up) begin
                    // A last word arriving in the very cycle the link dies ends the
                    // aborted packet here; otherwise keep discarding until its end.
                    if (accept && D_LAST) begin
                        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                        last_d  = sel_q;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DROP;
                    end
                end else if (accept && D_LAST) begin
                    last_d  = sel_q;
                    state_d = S_IDLE;
                end
            end
            S_DROP: begin
                if (accept && D_LAST) begin
                    if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                    last_d  = sel_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state: backpressure, FIFO push, busy flag.
    always_comb begin
        D_BP = 1'b1;
        push = 1'b0;
        BUSY = (state_q != S_IDLE);
        case (state_q)
            S_PKT: begin
                D_BP = sel_full;
                push = D_VALID && !sel_full && sel_up;
            end
            S_DROP:  D_BP = 1'b0;
            default: D_BP = 1'b1;
        endcase
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [DW:0]   mem_q [DEPTH];
        logic [AW-1:0] wptr_q, rptr_q;
        logic [AW:0]   cnt_q;
        logic          push_c, pop_c;
        logic [DW:0]   head;

        assign push_c      = push && (sel_q == CW'(c));
        assign pop_c       = TX_TVALID[c] && TX_TREADY[c];
        assign head        = mem_q[rptr_q];
        assign full_vec[c] = (cnt_q == CNT_FULL);
        assign TX_TVALID[c] = (cnt_q != '0) && CH_UP[c];
        assign TX_TLAST[c]  = head[DW];
        assign TX_TDATA[c*DW +: DW] = head[DW-1:0];

        // Pointer and occupancy tracking; a down channel is held flushed.
        always_ff @(posedge CLK or posedge SYS_RST) begin
            if (SYS_RST) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else if (!CH_UP[c]) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (push_c) wptr_q <= wptr_q + AW'(1);
                if (pop_c)  rptr_q <= rptr_q + AW'(1);
                cnt_q <= cnt_q + (AW+1)'(push_c) - (AW+1)'(pop_c);
            end
        end

        // Storage array; contents are only meaningful below the occupancy count.
        always_ff @(posedge CLK) begin
            if (push_c) mem_q[wptr_q] <= {D_LAST, D};
        end
    end

endmodule

// File: tb/tb_aurora_stripe_tx.sv
// Bench for aurora_stripe_tx: per-channel expected-word queues filled on acceptance
// and drained by a monitor on every observed pop, plus directed state checks.
module tb_aurora_stripe_tx;

    localparam int NCH   = 4;
    localparam int DW    = 64;
    localparam int DEPTH = 16;

    logic              CLK = 1'b0;
    logic              SYS_RST = 1'b1;
    logic [DW-1:0]     D = '0;
    logic              D_VALID = 1'b0;
    logic              D_LAST = 1'b0;
    logic              D_BP;
    logic [NCH-1:0]    CH_UP = '1;
    logic [NCH*DW-1:0] TX_TDATA;
    logic [NCH-1:0]    TX_TVALID;
    logic [NCH-1:0]    TX_TLAST;
    logic [NCH-1:0]    TX_TREADY = '1;
    logic              BUSY;
    logic [15:0]       DROP_CNT;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW:0] exp_q [NCH][$];
    bit          seen [NCH];
    logic [DW:0] mon_got, mon_want;

    aurora_stripe_tx #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .SYS_RST(SYS_RST), .D(D), .D_VALID(D_VALID), .D_LAST(D_LAST),
        .D_BP(D_BP), .CH_UP(CH_UP), .TX_TDATA(TX_TDATA), .TX_TVALID(TX_TVALID),
        .TX_TLAST(TX_TLAST), .TX_TREADY(TX_TREADY), .BUSY(BUSY), .DROP_CNT(DROP_CNT)
    );

    always #5 CLK = ~CLK;

    // Scoreboard monitor: every word popped must match the head of its channel queue.
    always @(negedge CLK) begin
        if (!SYS_RST) begin
            for (int c = 0; c < NCH; c++) begin
                if (TX_TVALID[c]) begin
                    seen[c] = 1'b1;
                    if (TX_TREADY[c]) begin
                        mon_got = {TX_TLAST[c], TX_TDATA[c*DW +: DW]};
                        n_cmp++;
                        if (exp_q[c].size() == 0) begin
                            n_err++;
                            $display("FAIL mon_ch%0d unexpected word got=%h required none", c, mon_got);
                        end else begin
                            mon_want = exp_q[c].pop_front();
                            if (mon_got !== mon_want) begin
                                n_err++;
                                $display("FAIL mon_ch%0d word got=%h required %h", c, mon_got, mon_want);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic do_reset();
        SYS_RST = 1'b1;
        D_VALID = 1'b0;
        D_LAST  = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        for (int c = 0; c < NCH; c++) exp_q[c].delete();
        SYS_RST = 1'b0;
    endtask

    // Present one word and hold it until accepted; ch<0 means the word must never appear.
    task automatic put_word(input int ch, input logic [DW-1:0] dat, input logic last);
        int waitc;
        D = dat;
        D_VALID = 1'b1;
        D_LAST = last;
        waitc = 0;
        @(negedge CLK);
        while (D_BP && waitc < 100) begin
            waitc++;
            @(negedge CLK);
        end
        n_cmp++;
        if (D_BP !== 1'b0) begin
            n_err++;
            $display("FAIL accept_timeout data=%h D_BP=%b required 0", dat, D_BP);
        end else if (ch >= 0) begin
            exp_q[ch].push_back({last, dat});
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic send_pkt(input int ch, input int nw, input logic [31:0] tag);
        for (int w = 0; w < nw; w++) put_word(ch, {tag, 32'(w)}, (w == nw - 1));
        D_VALID = 1'b0;
        D_LAST = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        int pend;
        t = 0;
        pend = 1;
        while (pend != 0 && t < 200) begin
            pend = 0;
            for (int c = 0; c < NCH; c++) pend += exp_q[c].size();
            if (pend != 0) begin
                @(posedge CLK);
                #1;
                t++;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            n_cmp++;
            if (exp_q[c].size() != 0) begin
                n_err++;
                $display("FAIL %s_pending_ch%0d left=%0d required 0", name, c, exp_q[c].size());
            end
        end
    endtask

    task automatic test_reset();
        SYS_RST = 1'b1;
        CH_UP = '0;
        @(negedge CLK);
        n_cmp++; if (TX_TVALID !== '0) begin n_err++; $display("FAIL rst_tvalid got=%b required 0000", TX_TVALID); end
        n_cmp++; if (D_BP !== 1'b1) begin n_err++; $display("FAIL rst_bp got=%b required 1", D_BP); end
        n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b required 0", BUSY); end
        n_cmp++; if (DROP_CNT !== 16'd0) begin n_err++; $display("FAIL rst_dropcnt got=%0d required 0", DROP_CNT); end
        do_reset();
        @(negedge CLK);
        n_cmp++; if (D_BP !== 1'b1) begin n_err++; $display("FAIL idle_nochan_bp got=%b required 1", D_BP); end
        n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL idle_nochan_busy got=%b required 0", BUSY); end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_round_robin();
        do_reset();
        CH_UP = '1;
        TX_TREADY = '1;
        for (int p = 0; p < 4; p++) send_pkt(p, 3, 32'hA000_0000 + p);
        drain("rr");
        n_cmp++; if (DROP_CNT !== 16'd0) begin n_err++; $display("FAIL rr_dropcnt got=%0d required 0", DROP_CNT); end
    endtask

    task automatic test_sparse();
        do_reset();
        CH_UP = 4'b1010;
        TX_TREADY = '1;
        for (int c = 0; c < NCH; c++) seen[c] = 1'b0;
        send_pkt(1, 2, 32'hB000_0001);
        send_pkt(3, 2, 32'hB000_0003);
        drain("sparse");
        n_cmp++; if (seen[0] !== 1'b0) begin n_err++; $display("FAIL sparse_ch0_valid got=%b required 0", seen[0]); end
        n_cmp++; if (seen[2] !== 1'b0) begin n_err++; $display("FAIL sparse_ch2_valid got=%b required 0", seen[2]); end
    endtask

    task automatic test_backpressure();
        do_reset();
        CH_UP = '1;
        TX_TREADY = 4'b1110;
        for (int w = 0; w < 16; w++) put_word(0, {32'hC000_0000, 32'(w)}, 1'b0);
        D = {32'hC000_0000, 32'd16};
        D_VALID = 1'b1;
        D_LAST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            n_cmp++; if (D_BP !== 1'b1) begin n_err++; $display("FAIL bp_full_cyc%0d got=%b required 1", k, D_BP); end
            n_cmp++; if (TX_TVALID[0] !== 1'b1) begin n_err++; $display("FAIL bp_tvalid_cyc%0d got=%b required 1", k, TX_TVALID[0]); end
            @(posedge CLK);
            #1;
        end
        TX_TREADY = '1;
        for (int w = 16; w < 20; w++) put_word(0, {32'hC000_0000, 32'(w)}, (w == 19));
        D_VALID = 1'b0;
        D_LAST = 1'b0;
        drain("bp");
    endtask

    task automatic test_drop();
        do_reset();
        CH_UP = '1;
        TX_TREADY = 4'b1110;
        put_word(-1, {32'hD000_0000, 32'd0}, 1'b0);
        put_word(-1, {32'hD000_0000, 32'd1}, 1'b0);
        CH_UP = 4'b1110;
        for (int w = 2; w < 5; w++) begin
            D = {32'hD000_0000, 32'(w)};
            D_VALID = 1'b1;
            D_LAST = (w == 4);
            @(negedge CLK);
            n_cmp++; if (D_BP !== 1'b0) begin n_err++; $display("FAIL drop_bp_w%0d got=%b required 0", w, D_BP); end
            @(posedge CLK);
            #1;
        end
        D_VALID = 1'b0;
        D_LAST = 1'b0;
        @(negedge CLK);
        n_cmp++; if (DROP_CNT !== 16'd1) begin n_err++; $display("FAIL drop_cnt got=%0d required 1", DROP_CNT); end
        n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL drop_idle_busy got=%b required 0", BUSY); end
        @(posedge CLK);
        #1;
        CH_UP = '1;
        TX_TREADY = '1;
        @(negedge CLK);
        n_cmp++; if (TX_TVALID[0] !== 1'b0) begin n_err++; $display("FAIL drop_flushed_ch0 got=%b required 0", TX_TVALID[0]); end
        @(posedge CLK);
        #1;
        send_pkt(1, 3, 32'hD000_0011);
        drain("drop");
    endtask

    task automatic test_reset_mid();
        CH_UP = '1;
        TX_TREADY = '0;
        put_word(-1, {32'hE000_0000, 32'd0}, 1'b0);
        put_word(-1, {32'hE000_0000, 32'd1}, 1'b0);
        SYS_RST = 1'b1;
        D_VALID = 1'b0;
        @(posedge CLK);
        #1;
        SYS_RST = 1'b0;
        for (int c = 0; c < NCH; c++) exp_q[c].delete();
        @(negedge CLK);
        n_cmp++; if (TX_TVALID !== '0) begin n_err++; $display("FAIL midrst_tvalid got=%b required 0000", TX_TVALID); end
        n_cmp++; if (D_BP !== 1'b1) begin n_err++; $display("FAIL midrst_bp got=%b required 1", D_BP); end
        n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b required 0", BUSY); end
        n_cmp++; if (DROP_CNT !== 16'd0) begin n_err++; $display("FAIL midrst_dropcnt got=%0d required 0", DROP_CNT); end
        @(posedge CLK);
        #1;
        TX_TREADY = '1;
        send_pkt(0, 3, 32'hE000_0010);
        drain("midrst");
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_sparse();
        test_backpressure();
        test_drop();
        test_reset_mid();
        repeat (4) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
